// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven Attack/Decay/Sustain/Release ramp advanced on sample ticks,
// producing a non-negative fixed-point gain for the multiplier's b_in operand.
module adsr_envelope #(
  parameter int WORD_LENGTH = 8,
  parameter int QI          = 2,
  parameter int FRAC_EXT    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   gate_in,
  input  logic [WORD_LENGTH-1:0] attack_step,
  input  logic [WORD_LENGTH-1:0] decay_step,
  input  logic [WORD_LENGTH-1:0] release_step,
  input  logic [WORD_LENGTH-1:0] sustain_level,
  output logic [WORD_LENGTH-1:0] env_out,
  output logic                   env_valid,
  output logic [2:0]             state_out,
  output logic                   active
);

  localparam int ACC_W = WORD_LENGTH + FRAC_EXT;
  localparam int CMP_W = ACC_W + 1;
  localparam logic [CMP_W-1:0] ONE = CMP_W'(1) << (WORD_LENGTH - QI + FRAC_EXT);
  localparam logic [WORD_LENGTH-1:0] UNITY = WORD_LENGTH'(1) << (WORD_LENGTH - QI);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CMP_W-1:0] acc_ext, a_ext, d_ext, r_ext, sus, attack_base, attack_sum;
  logic             attack_done, decay_done, release_done;

  // Sustain target clamped into 0..1.0 and widened to accumulator precision
  always_comb begin
    if (sustain_level[WORD_LENGTH-1])
      sus = '0;
    else if (sustain_level > UNITY)
      sus = ONE;
    else
      sus = CMP_W'({sustain_level, {FRAC_EXT{1'b0}}});
  end

  // All ramp arithmetic is done one bit wider than the accumulator so sums never wrap
  always_comb begin
    acc_ext      = {1'b0, acc_reg};
    a_ext        = CMP_W'(attack_step);
    d_ext        = CMP_W'(decay_step);
    r_ext        = CMP_W'(release_step);
    attack_base  = (state_reg == IDLE) ? '0 : acc_ext;
    attack_sum   = attack_base + a_ext;
    attack_done  = (attack_sum >= ONE) || (attack_step == '0);
    decay_done   = (acc_ext <= d_ext) || (decay_step == '0) || ((acc_ext - d_ext) <= sus);
    release_done = (acc_ext <= r_ext) || (release_step == '0);
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    case (state_reg)
      IDLE: begin
        acc_next = '0;
        if (gate_in) begin
          state_next = attack_done ? DECAY : ATTACK;
          acc_next   = attack_done ? ACC_W'(ONE) : ACC_W'(attack_sum);
        end
      end
      ATTACK: begin
        if (!gate_in) begin
          state_next = RELEASE;
        end else begin
          state_next = attack_done ? DECAY : ATTACK;
          acc_next   = attack_done ? ACC_W'(ONE) : ACC_W'(attack_sum);
        end
      end
      DECAY: begin
        if (!gate_in) begin
          state_next = RELEASE;
        end else if (decay_done) begin
          state_next = SUSTAIN;
          acc_next   = ACC_W'(sus);
        end else begin
          acc_next = ACC_W'(acc_ext - d_ext);
        end
      end
      SUSTAIN: begin
        if (!gate_in)
          state_next = RELEASE;
        else
          acc_next = ACC_W'(sus);
      end
      RELEASE: begin
        // A retrigger continues upward from the current level rather than restarting at zero
        if (gate_in) begin
          state_next = attack_done ? DECAY : ATTACK;
          acc_next   = attack_done ? ACC_W'(ONE) : ACC_W'(attack_sum);
        end else if (release_done) begin
          state_next = IDLE;
          acc_next   = '0;
        end else begin
          acc_next = ACC_W'(acc_ext - r_ext);
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      env_out   <= '0;
      env_valid <= 1'b0;
      state_out <= 3'd0;
      active    <= 1'b0;
    end else begin
      env_valid <= en;
      if (en) begin
        state_reg <= state_next;
        acc_reg   <= acc_next;
        env_out   <= acc_next[ACC_W-1:FRAC_EXT];
        state_out <= state_next;
        active    <= (state_next != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed checkpoint table, multi-cycle corner
// sequences, and randomized traffic compared against an integer reference model.
module tb_adsr_envelope;

  localparam int ONE = 16384;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic       clk = 1'b0;
  logic       reset, en, gate_in;
  logic [7:0] attack_step, decay_step, release_step, sustain_level;
  logic [7:0] env_out;
  logic       env_valid, active;
  logic [2:0] state_out;

  int errors = 0;
  int checks = 0;

  adsr_envelope dut (
    .clk(clk), .reset(reset), .en(en), .gate_in(gate_in),
    .attack_step(attack_step), .decay_step(decay_step),
    .release_step(release_step), .sustain_level(sustain_level),
    .env_out(env_out), .env_valid(env_valid), .state_out(state_out), .active(active)
  );

  always #5 clk = ~clk;

  // Reference model: envelope rules in plain integer arithmetic
  int m_state = 0;
  int m_acc   = 0;
  bit m_valid = 1'b0;

  function automatic void attack_from(input int base, input int a, output int nst, output int nacc);
    if (base + a >= ONE || a == 0) begin
      nst = S_DECAY; nacc = ONE;
    end else begin
      nst = S_ATTACK; nacc = base + a;
    end
  endfunction

  function automatic void model_next(input int st, input int acc, input bit g, input int a,
                                     input int d, input int r, input logic [7:0] s,
                                     output int nst, output int nacc);
    int sv, sus;
    sv = int'($signed(s));
    sus = (sv < 0) ? 0 : (sv > 64) ? ONE : sv * 256;
    nst = st; nacc = acc;
    case (st)
      S_IDLE:    if (g) attack_from(0, a, nst, nacc); else nacc = 0;
      S_ATTACK:  if (!g) nst = S_RELEASE; else attack_from(acc, a, nst, nacc);
      S_DECAY: begin
        if (!g) nst = S_RELEASE;
        else if (acc - d <= sus || d == 0 || acc <= d) begin nst = S_SUSTAIN; nacc = sus; end
        else nacc = acc - d;
      end
      S_SUSTAIN: if (!g) nst = S_RELEASE; else nacc = sus;
      default: begin
        if (g) attack_from(acc, a, nst, nacc);
        else if (acc <= r || r == 0) begin nst = S_IDLE; nacc = 0; end
        else nacc = acc - r;
      end
    endcase
  endfunction

  always @(posedge clk) begin : model_proc
    int ns, na;
    if (reset) begin
      m_state <= S_IDLE; m_acc <= 0; m_valid <= 1'b0;
    end else if (en) begin
      model_next(m_state, m_acc, gate_in, int'(attack_step), int'(decay_step),
                 int'(release_step), sustain_level, ns, na);
      m_state <= ns; m_acc <= na; m_valid <= 1'b1;
    end else begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input bit g);
    gate_in = g; en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit         gate;
    logic [7:0] a, d, r, s;
    int         n;
    logic [7:0] env;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int vcount;
    reset = 1'b1; en = 1'b0; gate_in = 1'b0;
    attack_step = 8'd0; decay_step = 8'd0; release_step = 8'd0; sustain_level = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_env", env_out, 0);
    check("reset_state", state_out, 0);
    check("reset_valid", env_valid, 0);
    check("reset_active", active, 0);
    reset = 1'b0;

    // Full ADSR cycle
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20, 127, 8'h3F, 3'd1});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20,   1, 8'h40, 3'd2});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20, 127, 8'h20, 3'd2});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20,   1, 8'h20, 3'd3});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20, 144, 8'h20, 3'd3});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd32, 8'h20,   1, 8'h20, 3'd4});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd32, 8'h20, 255, 8'h00, 3'd4});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd32, 8'h20,   1, 8'h00, 3'd0});
    // Zero steps
    vecs.push_back('{1, 8'd0, 8'd0, 8'd0, 8'h20, 1, 8'h40, 3'd2});
    vecs.push_back('{1, 8'd0, 8'd0, 8'd0, 8'h20, 1, 8'h20, 3'd3});
    vecs.push_back('{0, 8'd0, 8'd0, 8'd0, 8'h20, 1, 8'h20, 3'd4});
    vecs.push_back('{0, 8'd0, 8'd0, 8'd0, 8'h20, 1, 8'h00, 3'd0});
    // Sustain clamp and live tracking
    vecs.push_back('{1, 8'd0, 8'd0, 8'd0, 8'h20, 2, 8'h20, 3'd3});
    vecs.push_back('{1, 8'd0, 8'd0, 8'd0, 8'h7F, 1, 8'h40, 3'd3});
    vecs.push_back('{1, 8'd0, 8'd0, 8'd0, 8'h80, 1, 8'h00, 3'd3});
    vecs.push_back('{0, 8'd0, 8'd0, 8'd0, 8'h80, 2, 8'h00, 3'd0});
    // Early release and retrigger
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20, 64, 8'h20, 3'd1});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd32, 8'h20,  1, 8'h20, 3'd4});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd32, 8'h20, 10, 8'h1E, 3'd4});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20,  1, 8'h1F, 3'd1});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20, 65, 8'h3F, 3'd1});
    vecs.push_back('{1, 8'd128, 8'd64, 8'd32, 8'h20,  1, 8'h40, 3'd2});
    vecs.push_back('{0, 8'd128, 8'd64, 8'd255, 8'h20, 66, 8'h00, 3'd0});

    foreach (vecs[i]) begin
      attack_step = vecs[i].a; decay_step = vecs[i].d;
      release_step = vecs[i].r; sustain_level = vecs[i].s;
      for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].gate);
      $display("vec %0d: gate=%0d ticks=%0d env=0x%0h state=%0d active=%0d", i, vecs[i].gate,
               vecs[i].n, env_out, state_out, active);
      check($sformatf("vec%0d_env", i), env_out, vecs[i].env);
      check($sformatf("vec%0d_state", i), state_out, vecs[i].st);
      check($sformatf("vec%0d_active", i), active, (vecs[i].st != 3'd0));
      check($sformatf("vec%0d_valid", i), env_valid, 1);
    end

    // Reset mid-attack
    attack_step = 8'd128;
    for (int k = 0; k < 39; k++) tick(1'b1);
    check("midatk_env", env_out, 8'h13);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset mid-attack: env=0x%0h state=%0d valid=%0d", env_out, state_out, env_valid);
    check("midatk_rst_env", env_out, 0);
    check("midatk_rst_state", state_out, 0);
    check("midatk_rst_valid", env_valid, 0);
    check("midatk_rst_active", active, 0);
    tick(1'b1);
    check("restart_state", state_out, 1);
    check("restart_env0", env_out, 0);
    tick(1'b1);
    check("restart_env1", env_out, 1);

    // Sparse ticks with a short gate pulse between ticks
    do_reset();
    tick(1'b0);
    en = 1'b0; gate_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    gate_in = 1'b0;
    @(posedge clk); #1;
    tick(1'b0);
    $display("sparse gate pulse: state=%0d env=0x%0h", state_out, env_out);
    check("sparse_pulse_state", state_out, 0);
    check("sparse_pulse_env", env_out, 0);
    vcount = 0; gate_in = 1'b1; attack_step = 8'd255;
    for (int c = 0; c < 16; c++) begin
      en = (c % 4 == 0);
      @(posedge clk); #1;
      if (env_valid) vcount++;
      check($sformatf("sparse_valid_c%0d", c), env_valid, (c % 4 == 0));
    end
    en = 1'b0;
    $display("sparse ticks: valid pulses=%0d env=0x%0h state=%0d", vcount, env_out, state_out);
    check("sparse_valid_count", vcount, 4);
    check("sparse_env", env_out, 8'h03);
    check("sparse_state", state_out, 1);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 499) == 0) reset = 1'b1; else reset = 1'b0;
      en = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) gate_in = ~gate_in;
      if ($urandom_range(0, 149) == 0) attack_step  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 149) == 0) decay_step   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 149) == 0) release_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 99) == 0)  sustain_level = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      if (c % 500 == 0)
        $display("rand %0d: env=0x%0h state=%0d valid=%0d model acc=%0d state=%0d", c, env_out,
                 state_out, env_valid, m_acc, m_state);
      check($sformatf("rand%0d", c), {env_out, state_out, active, env_valid},
            {8'(m_acc >> 8), 3'(m_state), (m_state != S_IDLE), m_valid});
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

ADSR envelope generator for the discrete digital synthesizer. On each sample tick it advances a five-state Attack/Decay/Sustain/Release machine driven by a gate input, and it produces a non-negative fixed-point gain. That gain feeds the `b_in` operand of the downstream fixed-point multiplier; the oscillator sample drives `a_in`.

## Interface

Clocking: one clock, `clk`; reset `reset` is synchronous and active-high.

Parameters:
- `WORD_LENGTH`, 8: width of `env_out`, `sustain_level` and all step inputs.
- `QI`, 2: integer bits of `env_out`/`sustain_level`. The format is signed `[QI-1:-(WORD_LENGTH-QI)]`, matching the multiplier's B_QI.
- `FRAC_EXT`, 8: extra fraction bits in the internal accumulator, for slow ramps.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high. Has priority over all other inputs.
- `en`, in, 1: sample tick. State and accumulator change only on cycles with `en`=1.
- `gate_in`, in, 1: note held (level-sensitive, sampled on ticks).
- `attack_step`, in, WORD_LENGTH, unsigned: accumulator LSBs added per tick in ATTACK.
- `decay_step`, in, WORD_LENGTH, unsigned: LSBs subtracted per tick in DECAY.
- `release_step`, in, WORD_LENGTH, unsigned: LSBs subtracted per tick in RELEASE.
- `sustain_level`, in, WORD_LENGTH, signed, same format as `env_out`.
- `env_out`, out, WORD_LENGTH, signed `[QI-1:-(WORD_LENGTH-QI)]`: gain in the range 0..1.0.
- `env_valid`, out, 1: one-cycle pulse when `env_out` holds a new tick result.
- `state_out`, out, 3: current state encoding.
- `active`, out, 1: high when the state is not IDLE.

## Operation

Accumulator:
- `acc` is unsigned, ACC_W = WORD_LENGTH + FRAC_EXT bits.
- ONE = 2^(WORD_LENGTH-QI+FRAC_EXT); with the defaults ONE = 16384.
- `acc` always satisfies 0 ≤ `acc` ≤ ONE.
- `env_out` = `acc` >> FRAC_EXT, truncated, so the sign bit is always 0 and the maximum output is 1.0 (0x40 with defaults).
- SUS = clamp(`sustain_level`, 0, 1.0) << FRAC_EXT. A negative `sustain_level` gives SUS = 0; a value above 1.0 gives SUS = ONE.
- Comparisons use ACC_W+1 bits so that a sum never wraps.

State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Transitions are evaluated on `en` ticks only. Gate checks take precedence over ramp updates within a tick:
- IDLE:
  - With `gate_in`=1: go to ATTACK and apply one attack step in the same tick.
  - Otherwise: stay, `acc`=0.
- ATTACK:
  - With `gate_in`=0: go to RELEASE, leaving `acc` unchanged.
  - Else if `acc`+`attack_step` ≥ ONE, or `attack_step`=0: set `acc`=ONE and go to DECAY.
  - Else: `acc` += `attack_step`.
- DECAY:
  - With `gate_in`=0: go to RELEASE.
  - Else if `acc`−`decay_step` ≤ SUS, or `decay_step`=0, or `acc` ≤ `decay_step`: set `acc`=SUS and go to SUSTAIN.
  - Else: `acc` −= `decay_step`.
- SUSTAIN:
  - With `gate_in`=0: go to RELEASE.
  - Else: `acc`=SUS. This tracks live changes to `sustain_level`.
- RELEASE:
  - With `gate_in`=1: retrigger into ATTACK from the current `acc`, with no reset to 0, and apply one attack step.
  - Else if `acc` ≤ `release_step`, or `release_step`=0: set `acc`=0 and go to IDLE.
  - Else: `acc` −= `release_step`.

## Timing

- Every output is registered.
- `env_out`, `state_out` and `active` reflect a tick's result on the cycle after `en`=1. `env_valid` pulses high on that same cycle.
- Between ticks, all outputs hold their values and `env_valid`=0.
- Reset values: `acc`=0, state IDLE, `env_out`=0, `env_valid`=0, `state_out`=0, `active`=0.
- Reset asserted mid-envelope returns to IDLE on the next edge, regardless of `en` or `gate_in`.
- `en` held high every cycle is legal and gives one step per clock.
- A gate toggle between ticks is invisible; only the level on a tick counts.
- Step and sustain inputs may change at any time and are sampled on ticks.
- Latency from a gate edge to the first changed `env_out` is one tick plus one clock.

## Test plan

All scenarios use default parameters, `en` held at 1, and the numbering "tick 1" = first tick after gate goes high.

- **Full ADSR cycle.** Stimulus: `attack_step`=128, `decay_step`=64, `sustain_level`=0x20, `release_step`=32, gate high for 400 ticks, then low.
  - `env_out`=0x40 with DECAY entered at tick 128.
  - SUSTAIN entered at tick 256 with `env_out`=0x20.
  - After gate low, IDLE with `env_out`=0 after exactly 256 release ticks; `active` drops on the same cycle.
- **Reset mid-attack.** Assert `reset` during ATTACK at `acc`≈5000 → next cycle `env_out`=0, `state_out`=0, `env_valid`=0. Gate still high after reset release → ATTACK restarts from 0.
- **Early release and retrigger.**
  - Gate drops at attack tick 64 (`env_out`=0x20) → RELEASE from 0x20 with no jump.
  - Gate re-raised at release tick 10 → ATTACK from `acc`=8192−320=7872; DECAY reached after 67 more ticks.
- **Zero steps.** `attack_step`=0, `decay_step`=0, `release_step`=0:
  - Gate high → `env_out` 0x40 at tick 1, 0x20 (SUSTAIN) at tick 2.
  - Gate low → IDLE and 0 on the next tick.
- **Sustain clamp and tracking.** Hold in SUSTAIN, then:
  - Set `sustain_level`=0x7F → `env_out`=0x40.
  - Set `sustain_level`=0x80 (negative) → `env_out`=0x00 while the state stays SUSTAIN.
- **Sparse ticks.** `en` pulsed every 4th cycle → `acc` changes only on tick cycles, `env_valid` pulses once per tick, and a gate pulse lasting 2 cycles between ticks is ignored.
